cios_beta_pipe: RTL

CIOS_BETA_PIPE -- requirements
Module: cios_beta_pipe

---
 rtl/cios_pkg.sv | 20 ++
 rtl/cios_mul_reg.sv | 44 ++++
 rtl/cios_beta_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cios_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cios_pkg
// Desc     : Shared constants and types for the CIOS beta-step pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package cios_pkg;

   // Default operand word width and sideband tag width
   localparam int DEF_WIDTH  = 32;
   localparam int DEF_TAG_W  = 8;

   // Number of register stages between operand acceptance and result
   localparam int PIPE_DEPTH = 3;

   typedef logic [DEF_WIDTH-1:0]   word_t;
   typedef logic [2*DEF_WIDTH-1:0] dword_t;

endpackage
`default_nettype wire

// File: rtl/cios_mul_reg.sv
`default_nettype none
// ============================================================================
// Module   : cios_mul_reg
// Desc     : Registered WIDTH x WIDTH multiplier with load enable. PROD_W
//            selects how many low product bits are kept (WIDTH for a
//            modular low-word product, 2*WIDTH for the full product).
// Revision : 1.0 - initial release
// ============================================================================
module cios_mul_reg #(
   parameter int WIDTH  = 32,
   parameter int PROD_W = 2*WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic [PROD_W-1:0] p
);

   logic [PROD_W-1:0] p_d;
   logic [PROD_W-1:0] p_q;

   // Take a new product only when the owning stage loads; otherwise hold
   always_comb begin
      p_d = p_q;
      if (en) begin
         p_d = PROD_W'(a) * PROD_W'(b);
      end
   end

   // Product register, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign p = p_q;

endmodule
`default_nettype wire

// File: rtl/cios_beta_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cios_beta_pipe
// Desc     : Three-stage pipelined CIOS reduction step. For each T[0] it
//            produces m = LSW(T[0]*p') and carry-out MSW(T[0] + m*p[0]),
//            with valid/ready handshaking, bubble collapsing and sticky
//            error flags for a nonzero reduced low word and for a
//            configuration write attempted while operations are in flight.
// Revision : 1.0 - initial release
// ============================================================================
module cios_beta_pipe
   import cios_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [WIDTH-1:0] cfg_p0,
   input  logic [WIDTH-1:0] cfg_pprime,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sin,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_m,
   output logic [WIDTH-1:0] out_cout,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy,
   output logic             err_lsw,
   output logic             err_cfg
);

   localparam int S1 = 0;
   localparam int S2 = 1;
   localparam int S3 = 2;

   // Stage valid bits, index 0 is the stage nearest the input
   logic [PIPE_DEPTH-1:0] valid_d, valid_q;

   // Per-stage advance and load strobes
   logic adv1, adv2, adv3;
   logic ld1, ld2, ld3;
   logic busy_w;

   // Configuration and sticky flags
   logic [WIDTH-1:0] p0_d, p0_q;
   logic [WIDTH-1:0] pprime_d, pprime_q;
   logic             err_lsw_d, err_lsw_q;
   logic             err_cfg_d, err_cfg_q;

   // S1 payload (m itself lives in the first multiplier register)
   logic [WIDTH-1:0]   sin1_d, sin1_q;
   logic [TAG_W-1:0]   tag1_d, tag1_q;
   logic [WIDTH-1:0]   m1;

   // S2 payload (m*p0 lives in the second multiplier register)
   logic [WIDTH-1:0]   sin2_d, sin2_q;
   logic [WIDTH-1:0]   m2_d, m2_q;
   logic [TAG_W-1:0]   tag2_d, tag2_q;
   logic [2*WIDTH-1:0] prod2;

   // S3 payload; only the high word of t is kept, the low word feeds err_lsw
   logic [2*WIDTH-1:0] t_sum;
   logic [WIDTH-1:0]   m3_d, m3_q;
   logic [WIDTH-1:0]   cout3_d, cout3_q;
   logic [TAG_W-1:0]   tag3_d, tag3_q;

   // Stall chain: a stage moves when it is empty or its successor moves
   always_comb begin
      adv3 = ~valid_q[S3] | out_ready;
      adv2 = ~valid_q[S2] | adv3;
      adv1 = ~valid_q[S1] | adv2;

      ld1  = adv1 & in_valid;
      ld2  = adv2 & valid_q[S1];
      ld3  = adv3 & valid_q[S2];

      valid_d = valid_q;
      if (adv1) valid_d[S1] = in_valid;
      if (adv2) valid_d[S2] = valid_q[S1];
      if (adv3) valid_d[S3] = valid_q[S2];
   end

   assign busy_w = |valid_q;

   // m = LSW(sin * p'), registered into S1
   cios_mul_reg #(
      .WIDTH  (WIDTH),
      .PROD_W (WIDTH)
   ) u_mul_m (
      .clk (clk),
      .rst (rst),
      .en  (ld1),
      .a   (in_sin),
      .b   (pprime_q),
      .p   (m1)
   );

   // Full m * p0 product, registered into S2
   cios_mul_reg #(
      .WIDTH  (WIDTH),
      .PROD_W (2*WIDTH)
   ) u_mul_prod (
      .clk (clk),
      .rst (rst),
      .en  (ld2),
      .a   (m1),
      .b   (p0_q),
      .p   (prod2)
   );

   // Stage payload movement; registers only change on a real transfer so
   // outputs stay frozen while stalled and remain zero until the first result
   always_comb begin
      sin1_d  = sin1_q;
      tag1_d  = tag1_q;
      sin2_d  = sin2_q;
      m2_d    = m2_q;
      tag2_d  = tag2_q;
      m3_d    = m3_q;
      cout3_d = cout3_q;
      tag3_d  = tag3_q;

      t_sum = {{WIDTH{1'b0}}, sin2_q} + prod2;

      if (ld1) begin
         sin1_d = in_sin;
         tag1_d = in_tag;
      end
      if (ld2) begin
         sin2_d = sin1_q;
         m2_d   = m1;
         tag2_d = tag1_q;
      end
      if (ld3) begin
         m3_d    = m2_q;
         cout3_d = t_sum[2*WIDTH-1:WIDTH];
         tag3_d  = tag2_q;
      end
   end

   // Configuration loads only when idle so every in-flight op sees one config
   always_comb begin
      p0_d      = p0_q;
      pprime_d  = pprime_q;
      err_cfg_d = err_cfg_q;
      err_lsw_d = err_lsw_q;

      if (cfg_we) begin
         if (busy_w) begin
            err_cfg_d = 1'b1;
         end else begin
            p0_d     = cfg_p0;
            pprime_d = cfg_pprime;
         end
      end

      if (ld3 && (t_sum[WIDTH-1:0] != '0)) begin
         err_lsw_d = 1'b1;
      end
   end

   // All state registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= '0;
         p0_q      <= '0;
         pprime_q  <= '0;
         err_lsw_q <= 1'b0;
         err_cfg_q <= 1'b0;
         sin1_q    <= '0;
         tag1_q    <= '0;
         sin2_q    <= '0;
         m2_q      <= '0;
         tag2_q    <= '0;
         m3_q      <= '0;
         cout3_q   <= '0;
         tag3_q    <= '0;
      end else begin
         valid_q   <= valid_d;
         p0_q      <= p0_d;
         pprime_q  <= pprime_d;
         err_lsw_q <= err_lsw_d;
         err_cfg_q <= err_cfg_d;
         sin1_q    <= sin1_d;
         tag1_q    <= tag1_d;
         sin2_q    <= sin2_d;
         m2_q      <= m2_d;
         tag2_q    <= tag2_d;
         m3_q      <= m3_d;
         cout3_q   <= cout3_d;
         tag3_q    <= tag3_d;
      end
   end

   assign in_ready  = adv1;
   assign out_valid = valid_q[S3];
   assign out_m     = m3_q;
   assign out_cout  = cout3_q;
   assign out_tag   = tag3_q;
   assign busy      = busy_w;
   assign err_lsw   = err_lsw_q;
   assign err_cfg   = err_cfg_q;

endmodule
`default_nettype wire
